// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream for fifo_rd_stream.
interface fifo_rd_stream_if #(
  parameter int unsigned DSIZE = 8
);
  logic [DSIZE-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  // Adapter side: reads the FIFO and sources the stream
  modport master (
    input  fifo_dout, fifo_empty, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last
  );

  // Environment side: the FIFO and the stream consumer
  modport slave (
    output fifo_dout, fifo_empty, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a standard-mode FIFO into a registered valid/ready stream.
// Reads are issued against credits (buffered + in-flight words), so the
// small skid buffer can never overflow and m_ready never reaches fifo_rd_en.
module fifo_rd_stream #(
  parameter int unsigned DSIZE   = 8,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned PKT_LEN = 0,
  parameter int unsigned CW      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_rd_stream_if.master bus,
  output logic [CW-1:0]    beat_count
);
  localparam int unsigned BUF = LATENCY + 1;
  localparam int unsigned PW  = $clog2(BUF);
  localparam int unsigned NW  = $clog2(BUF + 1);
  localparam int unsigned IW  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [DSIZE-1:0]   buf_q [BUF];
  logic [DSIZE-1:0]   buf_d [BUF];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [NW-1:0]      nbuf_q, nbuf_d;
  logic [LATENCY-1:0] tag_q, tag_d;
  logic [IW-1:0]      beat_idx_q, beat_idx_d;
  logic [CW-1:0]      beat_count_q, beat_count_d;

  logic [NW-1:0]      ninf_c;
  logic [NW-1:0]      occ_c;
  logic               rd_en_c;
  logic               valid_c;
  logic               capture_c;
  logic               pop_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check: buffered plus in-flight words; this cycle's pop is not credited
  always_comb begin
    ninf_c = '0;
    for (int i = 0; i < int'(LATENCY); i++) begin
      ninf_c = ninf_c + NW'(tag_q[i]);
    end
    occ_c   = nbuf_q + ninf_c;
    rd_en_c = !bus.fifo_empty && (occ_c < NW'(BUF)) && rst_n;
  end

  assign valid_c   = (nbuf_q != '0);
  assign capture_c = tag_q[LATENCY-1];
  assign pop_c     = valid_c && bus.m_ready;

  // Next state: tag shift, capture at tail, pop at head, beat counters
  always_comb begin
    buf_d        = buf_q;
    head_d       = head_q;
    tail_d       = tail_q;
    nbuf_d       = nbuf_q;
    beat_idx_d   = beat_idx_q;
    beat_count_d = beat_count_q;
    tag_d        = LATENCY'({tag_q, rd_en_c});

    if (capture_c) begin
      buf_d[tail_q] = bus.fifo_dout;
      tail_d        = ptr_inc(tail_q);
    end

    if (pop_c) begin
      head_d       = ptr_inc(head_q);
      beat_count_d = beat_count_q + CW'(1);
      if (PKT_LEN > 1) begin
        beat_idx_d = (beat_idx_q == IW'(PKT_LEN - 1)) ? '0 : beat_idx_q + IW'(1);
      end
    end

    if (capture_c && !pop_c) begin
      nbuf_d = nbuf_q + NW'(1);
    end else if (!capture_c && pop_c) begin
      nbuf_d = nbuf_q - NW'(1);
    end
  end

  // State registers; reset also drops any reads still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q        <= '{default: '0};
      head_q       <= '0;
      tail_q       <= '0;
      nbuf_q       <= '0;
      tag_q        <= '0;
      beat_idx_q   <= '0;
      beat_count_q <= '0;
    end else begin
      buf_q        <= buf_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      nbuf_q       <= nbuf_d;
      tag_q        <= tag_d;
      beat_idx_q   <= beat_idx_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_c;
  assign bus.m_valid    = valid_c;
  assign bus.m_data     = buf_q[head_q];
  assign bus.m_last     = (PKT_LEN != 0) && valid_c && (beat_idx_q == IW'(PKT_LEN - 1));
  assign beat_count     = beat_count_q;
endmodule
